// File: rtl/evt_pulse_shaper_if.sv
// evt_pulse_shaper_if: event input, clear and shaped-pulse/status outputs of the pulse shaper
interface evt_pulse_shaper_if #(
    parameter int CNT_W = 4
);
    logic             evt_in;
    logic             clr;
    logic             pulse_out;
    logic [CNT_W-1:0] pending;
    logic             overflow;
    logic             busy;

    modport master (
        output evt_in, clr,
        input  pulse_out, pending, overflow, busy
    );

    modport slave (
        input  evt_in, clr,
        output pulse_out, pending, overflow, busy
    );
endinterface

// File: rtl/evt_pulse_shaper.sv
// evt_pulse_shaper: turns raw clk_f event levels into queued single-cycle pulses spaced MIN_GAP cycles apart
module evt_pulse_shaper #(
    parameter int MIN_GAP = 6,
    parameter int CNT_W   = 4
) (
    input logic               clk_f,
    input logic               rst_n,
    evt_pulse_shaper_if.slave bus
);
    localparam int GW = $clog2(MIN_GAP);
    localparam logic [GW-1:0] RELOAD = GW'(MIN_GAP - 1);
    localparam logic [CNT_W-1:0] FULL = '1;

    typedef enum logic {IDLE, GAP} state_t;

    state_t           state, state_nx;
    logic [GW-1:0]    gap_cnt, gap_nx;
    logic [CNT_W-1:0] pending;
    logic             evt_d, pulse_q, overflow_q, rise, emit;

    assign rise = bus.evt_in & ~evt_d & ~bus.clr;

    // Emit from IDLE on any backlog; in GAP leave one cycle early when nothing is queued, else re-emit at expiry
    always_comb begin
        state_nx = state;
        gap_nx   = gap_cnt;
        emit     = 1'b0;
        if (bus.clr) begin
            state_nx = IDLE;
            gap_nx   = '0;
        end else if (state == IDLE) begin
            emit     = pending != '0;
            state_nx = emit ? GAP : IDLE;
            gap_nx   = emit ? RELOAD : '0;
        end else if (gap_cnt == '0) begin
            emit     = pending != '0;
            state_nx = emit ? GAP : IDLE;
            gap_nx   = emit ? RELOAD : '0;
        end else if (gap_cnt == GW'(1) && pending == '0) begin
            state_nx = IDLE;
            gap_nx   = '0;
        end else begin
            gap_nx = gap_cnt - GW'(1);
        end
    end

    // FSM state and gap counter registers
    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_nx;
            gap_cnt <= gap_nx;
        end
    end

    // Edge detector, saturating pending counter, sticky overflow and registered pulse
    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) begin
            evt_d      <= 1'b0;
            pulse_q    <= 1'b0;
            pending    <= '0;
            overflow_q <= 1'b0;
        end else begin
            evt_d   <= bus.evt_in;
            pulse_q <= emit;
            if (bus.clr) begin
                pending    <= '0;
                overflow_q <= 1'b0;
            end else if (rise && !emit) begin
                if (pending == FULL)
                    overflow_q <= 1'b1;
                else
                    pending <= pending + CNT_W'(1);
            end else if (emit && !rise) begin
                pending <= pending - CNT_W'(1);
            end
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.pending   = pending;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = (state == GAP) || (pending != '0);
endmodule
